// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register with valid/ready handshake, optional skid buffer and flush-to-bubble.
// Define PIPE_STATS_EN to enable the saturating stall/bubble statistics counters.
module pipe_stage_skid #(
  parameter int                 DATA_W      = 40,
  parameter int                 CTRL_W      = 9,
  parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = '0,
  parameter int                 SKID        = 1,
  parameter int                 CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  logic              w_valid;
  logic              w_in_ready;
  logic [DATA_W-1:0] w_data;
  logic [CTRL_W-1:0] w_ctrl;
  logic [1:0]        w_occ;

  generate
    if (SKID != 0) begin : g_skid
      state_t            r_state;
      state_t            w_state_next;
      logic              r_in_ready;
      logic [DATA_W-1:0] r_main_data, r_skid_data;
      logic [CTRL_W-1:0] r_main_ctrl, r_skid_ctrl;
      logic              w_in_fire, w_out_fire;
      logic              w_load_main, w_load_skid, w_skid_to_main;

      assign w_in_fire  = in_valid & r_in_ready;
      assign w_out_fire = (r_state != S_EMPTY) & out_ready;

      always_comb begin
        w_state_next   = r_state;
        w_load_main    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_main = 1'b0;
        case (r_state)
          S_EMPTY: if (w_in_fire) begin
            w_state_next = S_ONE;
            w_load_main  = 1'b1;
          end
          S_ONE: begin
            if (w_in_fire && w_out_fire) begin
              w_load_main = 1'b1;
            end else if (w_in_fire) begin
              w_state_next = S_FULL;
              w_load_skid  = 1'b1;
            end else if (w_out_fire) begin
              w_state_next = S_EMPTY;
            end
          end
          S_FULL: if (w_out_fire) begin
            w_state_next   = S_ONE;
            w_skid_to_main = 1'b1;
          end
          default: w_state_next = S_EMPTY;
        endcase
        // Flush wins over every transfer, including a beat offered this cycle.
        if (flush) begin
          w_state_next   = S_EMPTY;
          w_load_main    = 1'b0;
          w_load_skid    = 1'b0;
          w_skid_to_main = 1'b0;
        end
      end

      // in_ready is registered from the next state so out_ready never reaches it combinationally.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_state    <= S_EMPTY;
          r_in_ready <= 1'b1;
        end else begin
          r_state    <= w_state_next;
          r_in_ready <= (w_state_next != S_FULL);
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_main_data <= '0;
          r_main_ctrl <= '0;
          r_skid_data <= '0;
          r_skid_ctrl <= '0;
        end else if (flush) begin
          r_main_data <= '0;
          r_main_ctrl <= '0;
          r_skid_data <= '0;
          r_skid_ctrl <= '0;
        end else begin
          if (w_load_main) begin
            r_main_data <= in_data;
            r_main_ctrl <= in_ctrl;
          end else if (w_skid_to_main) begin
            r_main_data <= r_skid_data;
            r_main_ctrl <= r_skid_ctrl;
          end
          if (w_load_skid) begin
            r_skid_data <= in_data;
            r_skid_ctrl <= in_ctrl;
          end
        end
      end

      assign w_valid    = (r_state != S_EMPTY);
      assign w_in_ready = r_in_ready;
      assign w_data     = r_main_data;
      assign w_ctrl     = r_main_ctrl;
      assign w_occ      = r_state;
    end else begin : g_reg
      logic              r_valid;
      logic [DATA_W-1:0] r_data;
      logic [CTRL_W-1:0] r_ctrl;

      assign w_in_ready = !r_valid | out_ready;

      // Payload is only overwritten by a real beat, so it holds after a drain.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_valid <= 1'b0;
          r_data  <= '0;
          r_ctrl  <= '0;
        end else if (flush) begin
          r_valid <= 1'b0;
          r_data  <= '0;
          r_ctrl  <= '0;
        end else if (w_in_ready) begin
          r_valid <= in_valid;
          if (in_valid) begin
            r_data <= in_data;
            r_ctrl <= in_ctrl;
          end
        end
      end

      assign w_valid = r_valid;
      assign w_data  = r_data;
      assign w_ctrl  = r_ctrl;
      assign w_occ   = {1'b0, r_valid};
    end
  endgenerate

  assign in_ready  = w_in_ready;
  assign out_valid = w_valid;
  assign out_data  = w_data;
  assign out_ctrl  = w_valid ? w_ctrl : CTRL_BUBBLE;
  assign occupancy = w_occ;

`ifdef PIPE_STATS_EN
  logic [CNT_W-1:0] r_stall_cnt, r_bubble_cnt;

  // Saturating counters; flush deliberately leaves them alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (!w_valid && (r_bubble_cnt != {CNT_W{1'b1}}))
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: a SKID=1 instance (A) and a SKID=0 instance (B)
// compared each cycle against a queue-based model of the stage.
module tb_pipe_stage_skid;

  localparam logic [8:0] BUB_A = 9'h0A5;
  localparam logic [8:0] BUB_B = 9'h15A;
`ifdef PIPE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct packed { logic [39:0] d; logic [8:0] c; } beat_t;
  typedef logic [52:0] obs_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [39:0] a_in_data, a_out_data;
  logic [8:0]  a_in_ctrl, a_out_ctrl;
  logic [1:0]  a_occ;
  logic [3:0]  a_stall, a_bubble;
  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [39:0] b_in_data, b_out_data;
  logic [8:0]  b_in_ctrl, b_out_ctrl;
  logic [1:0]  b_occ;
  logic [3:0]  b_stall, b_bubble;

  pipe_stage_skid #(.DATA_W(40), .CTRL_W(9), .CTRL_BUBBLE(BUB_A), .SKID(1), .CNT_W(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_ctrl(a_in_ctrl),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_ctrl(a_out_ctrl),
    .occupancy(a_occ), .stall_cnt(a_stall), .bubble_cnt(a_bubble));

  pipe_stage_skid #(.DATA_W(40), .CTRL_W(9), .CTRL_BUBBLE(BUB_B), .SKID(0), .CNT_W(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_ctrl(b_in_ctrl),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_ctrl(b_out_ctrl),
    .occupancy(b_occ), .stall_cnt(b_stall), .bubble_cnt(b_bubble));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: ordered queues of held beats plus the last value seen on the payload.
  beat_t       qa[$], qb[$];
  logic [39:0] last_a, last_b;
  int          stall_m, bubble_m;
  logic [39:0] obs_a[$], obs_b[$];

  always @(negedge clk) begin
    if (reset_n === 1'b1 && a_out_valid && a_out_ready) obs_a.push_back(a_out_data);
    if (reset_n === 1'b1 && b_out_valid && b_out_ready) obs_b.push_back(b_out_data);
  end

  function automatic obs_t exp_a();
    if (qa.size() != 0) return {1'b1, qa[0].d, qa[0].c, qa.size() < 2, 2'(qa.size())};
    return {1'b0, last_a, BUB_A, 1'b1, 2'd0};
  endfunction

  function automatic obs_t exp_b();
    if (qb.size() != 0) return {1'b1, qb[0].d, qb[0].c, b_out_ready, 2'd1};
    return {1'b0, last_b, BUB_B, 1'b1, 2'd0};
  endfunction

  function automatic obs_t act_a();
    return {a_out_valid, a_out_data, a_out_ctrl, a_in_ready, a_occ};
  endfunction

  function automatic obs_t act_b();
    return {b_out_valid, b_out_data, b_out_ctrl, b_in_ready, b_occ};
  endfunction

  task automatic model_reset();
    qa.delete(); qb.delete();
    last_a = '0; last_b = '0;
    stall_m = 0; bubble_m = 0;
  endtask

  task automatic idle_inputs();
    a_flush = 0; a_in_valid = 0; a_out_ready = 0; a_in_data = '0; a_in_ctrl = '0;
    b_flush = 0; b_in_valid = 0; b_out_ready = 0; b_in_data = '0; b_in_ctrl = '0;
  endtask

  // Advance one clock and apply the transfer rules to the model; ends 1 time unit after the edge.
  task automatic tick();
    bit a_in, a_out, b_in, b_out;
    a_in  = a_in_valid && (qa.size() < 2);
    a_out = (qa.size() != 0) && a_out_ready;
    b_in  = b_in_valid && ((qb.size() == 0) || b_out_ready);
    b_out = (qb.size() != 0) && b_out_ready;
    if (qa.size() != 0 && !a_out_ready && stall_m != 15) stall_m++;
    if (qa.size() == 0 && bubble_m != 15) bubble_m++;
    @(posedge clk);
    if (a_flush) begin
      qa.delete(); last_a = '0;
    end else begin
      if (a_out) begin last_a = qa[0].d; void'(qa.pop_front()); end
      if (a_in) qa.push_back('{a_in_data, a_in_ctrl});
    end
    if (b_flush) begin
      qb.delete(); last_b = '0;
    end else begin
      if (b_out) begin last_b = qb[0].d; void'(qb.pop_front()); end
      if (b_in) qb.push_back('{b_in_data, b_in_ctrl});
    end
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    model_reset();
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    n_checks++;
    if (act_a() !== exp_a()) begin n_fail++; $display("FAIL reset_a got=%h exp=%h", act_a(), exp_a()); end
    n_checks++;
    if (act_b() !== exp_b()) begin n_fail++; $display("FAIL reset_b got=%h exp=%h", act_b(), exp_b()); end
    n_checks++;
    if ({a_stall, a_bubble} !== 8'h00) begin n_fail++; $display("FAIL reset_cnt got=%h exp=00", {a_stall, a_bubble}); end
    #10 reset_n = 1'b1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_stream();
    idle_inputs();
    obs_a.delete();
    a_out_ready = 1;
    for (int i = 1; i <= 12; i++) begin
      a_in_valid = (i <= 10);
      a_in_data  = 40'(i);
      a_in_ctrl  = 9'($urandom);
      #1;
      n_checks++;
      if (act_a() !== exp_a()) begin n_fail++; $display("FAIL stream cyc=%0d got=%h exp=%h", i, act_a(), exp_a()); end
      tick();
    end
    n_checks++;
    if (obs_a.size() != 10) begin n_fail++; $display("FAIL stream_count got=%0d exp=10", obs_a.size()); end
    for (int i = 0; i < obs_a.size() && i < 10; i++) begin
      n_checks++;
      if (obs_a[i] !== 40'(i + 1)) begin n_fail++; $display("FAIL stream_order idx=%0d got=%h exp=%h", i, obs_a[i], i + 1); end
    end
    $display("test_stream done, %0d beats delivered", obs_a.size());
  endtask

  task automatic test_backpressure();
    logic [39:0] seq [3];
    int sent;
    bit acc;
    seq[0] = 40'h11; seq[1] = 40'h22; seq[2] = 40'h33;
    idle_inputs();
    obs_a.delete();
    sent = 0;
    for (int i = 0; i < 16; i++) begin
      a_out_ready = (i >= 6);
      a_in_valid  = (sent < 3);
      a_in_data   = (sent < 3) ? seq[sent] : 40'h0;
      a_in_ctrl   = 9'(sent + 3);
      #1;
      n_checks++;
      if (act_a() !== exp_a()) begin n_fail++; $display("FAIL backpressure cyc=%0d got=%h exp=%h", i, act_a(), exp_a()); end
      if (i == 5) begin
        n_checks++;
        if ({a_occ, a_in_ready, a_out_data} !== {2'd2, 1'b0, 40'h11}) begin
          n_fail++; $display("FAIL bp_full got occ=%0d rdy=%b data=%h exp occ=2 rdy=0 data=11", a_occ, a_in_ready, a_out_data);
        end
      end
      acc = a_in_valid && (qa.size() < 2);
      tick();
      if (acc) sent++;
    end
    n_checks++;
    if (obs_a.size() != 3) begin n_fail++; $display("FAIL bp_count got=%0d exp=3", obs_a.size()); end
    for (int i = 0; i < obs_a.size() && i < 3; i++) begin
      n_checks++;
      if (obs_a[i] !== seq[i]) begin n_fail++; $display("FAIL bp_order idx=%0d got=%h exp=%h", i, obs_a[i], seq[i]); end
    end
    $display("test_backpressure done, %0d beats delivered", obs_a.size());
  endtask

  task automatic test_flush_full();
    idle_inputs();
    obs_a.delete();
    a_in_valid = 1; a_in_data = 40'h61; a_in_ctrl = 9'h061; tick();
    a_in_data = 40'h62; a_in_ctrl = 9'h062; tick();
    a_in_data = 40'h44; a_in_ctrl = 9'h044; a_flush = 1;
    #1;
    n_checks++;
    if (act_a() !== exp_a()) begin n_fail++; $display("FAIL flush_pre got=%h exp=%h", act_a(), exp_a()); end
    tick();
    a_flush = 0; a_in_valid = 0;
    n_checks++;
    if ({a_out_valid, a_out_ctrl, a_occ, a_in_ready, a_out_data} !== {1'b0, BUB_A, 2'd0, 1'b1, 40'h0}) begin
      n_fail++; $display("FAIL flush_state got=%h exp=%h", {a_out_valid, a_out_ctrl, a_occ, a_in_ready, a_out_data},
                         {1'b0, BUB_A, 2'd0, 1'b1, 40'h0});
    end
    a_out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (act_a() !== exp_a()) begin n_fail++; $display("FAIL flush_post cyc=%0d got=%h exp=%h", i, act_a(), exp_a()); end
      tick();
    end
    n_checks++;
    if (obs_a.size() != 0) begin n_fail++; $display("FAIL flush_leak got=%0d beats exp=0", obs_a.size()); end
    $display("test_flush_full done");
  endtask

  task automatic test_async_reset();
    idle_inputs();
    a_out_ready = 0; b_out_ready = 0;
    a_in_valid = 1; b_in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      a_in_data = 40'(32'hA0 + i); b_in_data = 40'(32'hB0 + i);
      a_in_ctrl = 9'($urandom); b_in_ctrl = 9'($urandom);
      tick();
    end
    #1 reset_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (act_a() !== exp_a()) begin n_fail++; $display("FAIL areset_a got=%h exp=%h", act_a(), exp_a()); end
    n_checks++;
    if (act_b() !== exp_b()) begin n_fail++; $display("FAIL areset_b got=%h exp=%h", act_b(), exp_b()); end
    n_checks++;
    if ({a_stall, a_bubble} !== 8'h00) begin n_fail++; $display("FAIL areset_cnt got=%h exp=00", {a_stall, a_bubble}); end
    #1 reset_n = 1'b1;
    b_in_valid = 0;
    a_in_data = 40'h55; a_in_ctrl = 9'h055;
    tick();
    a_in_valid = 0;
    n_checks++;
    if ({a_out_valid, a_out_data, a_out_ctrl} !== {1'b1, 40'h55, 9'h055}) begin
      n_fail++; $display("FAIL areset_55 got v=%b d=%h c=%h exp v=1 d=55 c=055", a_out_valid, a_out_data, a_out_ctrl);
    end
    a_out_ready = 1; tick();
    $display("test_async_reset done");
  endtask

  task automatic test_skid0();
    logic [39:0] sent_q[$];
    int nxt;
    bit acc;
    idle_inputs();
    obs_b.delete();
    nxt = 0;
    for (int i = 0; i < 16; i++) begin
      b_out_ready = (i >= 12) ? 1'b1 : ((i % 2) == 0);
      b_in_valid  = (i < 12);
      b_in_data   = 40'(32'h71 + nxt);
      b_in_ctrl   = 9'(nxt);
      #1;
      n_checks++;
      if (act_b() !== exp_b()) begin n_fail++; $display("FAIL skid0 cyc=%0d got=%h exp=%h", i, act_b(), exp_b()); end
      acc = b_in_valid && ((qb.size() == 0) || b_out_ready);
      if (acc) sent_q.push_back(b_in_data);
      tick();
      if (acc) nxt++;
    end
    n_checks++;
    if (obs_b.size() != sent_q.size() || sent_q.size() == 0) begin
      n_fail++; $display("FAIL skid0_count got=%0d exp=%0d", obs_b.size(), sent_q.size());
    end
    for (int i = 0; i < obs_b.size() && i < sent_q.size(); i++) begin
      n_checks++;
      if (obs_b[i] !== sent_q[i]) begin n_fail++; $display("FAIL skid0_order idx=%0d got=%h exp=%h", i, obs_b[i], sent_q[i]); end
    end
    $display("test_skid0 done, %0d beats delivered", obs_b.size());
  endtask

  task automatic test_stats();
    idle_inputs();
    #1 reset_n = 1'b0;
    model_reset();
    #1 reset_n = 1'b1;
    a_in_valid = 1; a_in_data = 40'h99; a_in_ctrl = 9'h099;
    tick();
    a_in_valid = 0;
    repeat (20) tick();
    n_checks++;
    if ({a_stall, a_bubble} !== {(STATS ? 4'd15 : 4'd0), (STATS ? 4'd1 : 4'd0)}) begin
      n_fail++; $display("FAIL stats_sat got stall=%0d bubble=%0d exp stall=%0d bubble=%0d", a_stall, a_bubble,
                         STATS ? 15 : 0, STATS ? 1 : 0);
    end
    a_flush = 1; tick(); a_flush = 0;
    repeat (3) tick();
    n_checks++;
    if ({a_stall, a_bubble} !== {(STATS ? 4'd15 : 4'd0), (STATS ? 4'd4 : 4'd0)}) begin
      n_fail++; $display("FAIL stats_flush got stall=%0d bubble=%0d exp stall=%0d bubble=%0d", a_stall, a_bubble,
                         STATS ? 15 : 0, STATS ? 4 : 0);
    end
    n_checks++;
    if ({a_stall, a_bubble} !== (STATS ? {4'(stall_m), 4'(bubble_m)} : 8'h00)) begin
      n_fail++; $display("FAIL stats_model got=%h exp=%h", {a_stall, a_bubble}, {4'(stall_m), 4'(bubble_m)});
    end
    $display("test_stats done (stats %0s)", STATS ? "enabled" : "disabled");
  endtask

  task automatic test_random();
    int errs_before;
    errs_before = n_fail;
    for (int i = 0; i < 400; i++) begin
      a_in_valid  = $urandom_range(0, 3) != 0;
      a_out_ready = $urandom_range(0, 2) != 0;
      a_flush     = $urandom_range(0, 19) == 0;
      a_in_data   = {8'($urandom), 32'($urandom)};
      a_in_ctrl   = 9'($urandom);
      b_in_valid  = $urandom_range(0, 1) != 0;
      b_out_ready = $urandom_range(0, 1) != 0;
      b_flush     = $urandom_range(0, 19) == 0;
      b_in_data   = {8'($urandom), 32'($urandom)};
      b_in_ctrl   = 9'($urandom);
      #1;
      n_checks++;
      if (act_a() !== exp_a()) begin n_fail++; $display("FAIL random_a cyc=%0d got=%h exp=%h", i, act_a(), exp_a()); end
      n_checks++;
      if (act_b() !== exp_b()) begin n_fail++; $display("FAIL random_b cyc=%0d got=%h exp=%h", i, act_b(), exp_b()); end
      n_checks++;
      if ({a_stall, a_bubble} !== (STATS ? {4'(stall_m), 4'(bubble_m)} : 8'h00)) begin
        n_fail++; $display("FAIL random_cnt cyc=%0d got=%h exp=%h", i, {a_stall, a_bubble}, {4'(stall_m), 4'(bubble_m)});
      end
      tick();
    end
    $display("test_random done, %0d new failures", n_fail - errs_before);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_full();
    test_async_reset();
    test_skid0();
    test_stats();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
